adc_sample_capture: RTL

- Sits directly upstream of drec_controller. Produces the adc_data/adc_enable sample stream that drec_controller writes to SDRAM.
- Drives the board's 8-channel SPI ADC (ADC128S022-class, 16-clock frames) at a fixed sample rate.
- Converts each 12-bit offset-binary result to 16-bit two's-complement, the same format as the DAC path.

---
 rtl/drec_pkg.sv | 24 ++
 rtl/adc_sample_timer.sv | 34 +++
 rtl/adc_sample_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/drec_pkg.sv
// Shared types and constants for the record path (ADC capture and friends).
package drec_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StHold
    } adc_state_e;

    localparam int unsigned ADC_FRAME_BITS  = 16;
    // Falling edge on which the ADC expects the address MSB (ADD2).
    localparam int unsigned ADDR_MSB_EDGE   = 3;
    // First rising edge that carries a conversion bit (after 4 leading zeros).
    localparam int unsigned DATA_FIRST_EDGE = 5;
    localparam int unsigned ADC_RAW_W       = 12;
    localparam int unsigned SAMPLE_W        = 16;

    // Offset-binary ADC code to left-justified two's complement.
    function automatic logic [SAMPLE_W-1:0] offset_to_twos(input logic [ADC_RAW_W-1:0] raw);
        return {~raw[ADC_RAW_W-1], raw[ADC_RAW_W-2:0], {(SAMPLE_W - ADC_RAW_W){1'b0}}};
    endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// Free-running sample-rate counter: one-cycle tick every PERIOD cycles while enabled.
module adc_sample_timer #(
    parameter int unsigned PERIOD = 2500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count_q, count_d;

    assign tick_o = enable_i && (count_q == CW'(PERIOD - 1));

    // Next count: held at zero while disabled, wraps after the tick.
    always_comb begin
        count_d = count_q + 1'b1;
        if (!enable_i || tick_o) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_sample_capture.sv
// SPI ADC frame engine: periodic 16-clock frames, address out, 12-bit result in,
// converted to 16-bit two's complement with a one-cycle update strobe.
module adc_sample_capture
    import drec_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 20,
    parameter int unsigned SAMPLE_PERIOD = 2500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [2:0]          channel,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_din,
    input  logic                adc_dout,
    output logic [SAMPLE_W-1:0] adc_data,
    output logic                adc_enable,
    output logic                busy
);

    localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HalfLast = 2 * ADC_FRAME_BITS - 1;
    // Bit position of ADD0 inside the 8-bit control byte.
    localparam int unsigned AddrLsb  = 8 - (ADDR_MSB_EDGE + 2);

    logic tick;

    adc_sample_timer #(
        .PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable_i(enable),
        .tick_o  (tick)
    );

    adc_state_e           state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [4:0]           half_q, half_d;
    logic [2:0]           chan_q, chan_d;
    // Only the 12 conversion bits are kept; the 4 leading zeros are never captured.
    logic [ADC_RAW_W-1:0] shift_q, shift_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 din_q, din_d;
    logic                 strobe_q, strobe_d;
    logic                 busy_q, busy_d;
    logic [SAMPLE_W-1:0]  data_q, data_d;

    logic                 div_end;
    logic                 adv;
    logic [4:0]           half_nxt;
    logic [7:0]           ctrl_byte;

    assign div_end = (div_q == DivW'(CLK_DIV - 1));

    // Next-state: frame sequencing plus the sclk/din/capture action of each half-period.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        chan_d    = chan_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        strobe_d  = 1'b0;
        busy_d    = busy_q;
        data_d    = data_q;
        adv       = 1'b0;
        half_nxt  = '0;
        ctrl_byte = '0;
        ctrl_byte[AddrLsb +: 3] = chan_q;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    chan_d  = channel;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_end) begin
                    adv      = 1'b1;
                    half_nxt = '0;
                    state_d  = StShift;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_end) begin
                    if (half_q == 5'(HalfLast)) begin
                        div_d   = '0;
                        state_d = StHold;
                    end else begin
                        adv      = 1'b1;
                        half_nxt = half_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHold: begin
                if (div_end) begin
                    cs_n_d   = 1'b1;
                    busy_d   = 1'b0;
                    strobe_d = 1'b1;
                    data_d   = offset_to_twos(shift_q);
                    state_d  = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Even half index = falling edge (drive din), odd = rising edge (sample dout).
        if (adv) begin
            div_d  = '0;
            half_d = half_nxt;
            sclk_d = half_nxt[0];
            if (!half_nxt[0]) begin
                din_d = !half_nxt[4] && ctrl_byte[~half_nxt[3:1]];
            end else if (half_nxt[4:1] >= 4'(DATA_FIRST_EDGE - 1)) begin
                shift_d = {shift_q[ADC_RAW_W-2:0], adc_dout};
            end
        end
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            half_q   <= '0;
            chan_q   <= '0;
            shift_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            half_q   <= half_d;
            chan_q   <= chan_d;
            shift_q  <= shift_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
        end
    end

    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;
    assign adc_din    = din_q;
    assign adc_data   = data_q;
    assign adc_enable = strobe_q;
    assign busy       = busy_q;

endmodule
